// File: rtl/eq_biquad_scheduler_if.sv
// Sample, coefficient-write and band-output bundle for the shared-MAC equalizer.
// Latency: none (wires only).
// Backpressure: none; the source watches busy/overrun, the mixer consumes on out_valid.
interface eq_biquad_scheduler_if;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               coef_we;
    logic [1:0]         coef_band;
    logic [2:0]         coef_idx;
    logic signed [15:0] coef_data;
    logic               coef_commit;
    logic signed [15:0] low_out;
    logic signed [15:0] mid_out;
    logic signed [15:0] high_out;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    // Sample source / coefficient host side
    modport master (
        output sample_in, sample_valid, coef_we, coef_band, coef_idx, coef_data, coef_commit,
        input  low_out, mid_out, high_out, out_valid, busy, overrun
    );

    // Equalizer side
    modport slave (
        input  sample_in, sample_valid, coef_we, coef_band, coef_idx, coef_data, coef_commit,
        output low_out, mid_out, high_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/eq_biquad_scheduler.sv
// Three-band biquad equalizer time-sharing one 16x16 MAC; double-buffered coefficients.
// Latency: 18 cycles from sample accept to the out_valid strobe; one sample per 19 cycles max.
// Backpressure: none; a sample arriving while busy is dropped and sets the sticky overrun flag.
module eq_biquad_scheduler #(
    parameter int ACC_W = 36,
    parameter int FRAC  = 14
) (
    input  logic               clk,
    input  logic               reset,
    eq_biquad_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, WB = 2'd2} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

    state_t             state;
    logic [1:0]         band;
    logic [2:0]         tap;
    logic signed [15:0] x_cur, x1, x2;
    logic signed [15:0] y1 [3];
    logic signed [15:0] y2 [3];
    logic signed [ACC_W-1:0] acc;
    logic signed [15:0] shadow [3][5];
    logic signed [15:0] active [3][5];
    logic               pending;
    logic signed [15:0] low_r, mid_r, high_r;
    logic               valid_r, busy_r, overrun_r;

    logic signed [15:0]      coef, opnd, result;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext, acc_sh;

    assign bus.low_out   = low_r;
    assign bus.mid_out   = mid_r;
    assign bus.high_out  = high_r;
    assign bus.out_valid = valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;

    // Operand select for the current tap, product, and scaled/saturated band result
    always_comb begin
        coef = active[band][tap];
        case (tap)
            3'd0:    opnd = x_cur;
            3'd1:    opnd = x1;
            3'd2:    opnd = x2;
            3'd3:    opnd = y1[band];
            default: opnd = y2[band];
        endcase
        prod     = 32'(coef) * 32'(opnd);
        prod_ext = {{(ACC_W-32){prod[31]}}, prod};
        acc_sh   = acc >>> FRAC;
        if (acc_sh > SAT_MAX)
            result = 16'sh7fff;
        else if (acc_sh < SAT_MIN)
            result = 16'sh8000;
        else
            result = acc_sh[15:0];
    end

    // Shadow bank: host writes land here at any time; invalid band/idx are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 3; b++)
                for (int i = 0; i < 5; i++)
                    shadow[b][i] <= (i == 0) ? 16'sd16384 : 16'sd0;
        end else if (bus.coef_we && bus.coef_band != 2'd3 && bus.coef_idx <= 3'd4) begin
            shadow[bus.coef_band][bus.coef_idx] <= bus.coef_data;
        end
    end

    // Sequencer: accept, 5 MACs per band, write-back, history shift; active bank swap on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            band      <= 2'd0;
            tap       <= 3'd0;
            x_cur     <= '0;
            x1        <= '0;
            x2        <= '0;
            acc       <= '0;
            pending   <= 1'b0;
            low_r     <= '0;
            mid_r     <= '0;
            high_r    <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                y1[b] <= '0;
                y2[b] <= '0;
                for (int i = 0; i < 5; i++)
                    active[b][i] <= (i == 0) ? 16'sd16384 : 16'sd0;
            end
        end else begin
            valid_r <= 1'b0;
            if (bus.sample_valid && state != IDLE)
                overrun_r <= 1'b1;
            case (state)
                IDLE: begin
                    if (bus.sample_valid) begin
                        x_cur  <= bus.sample_in;
                        acc    <= '0;
                        band   <= 2'd0;
                        tap    <= 3'd0;
                        busy_r <= 1'b1;
                        state  <= MAC;
                        // The copy uses the pre-edge shadow, so a same-edge write is not included
                        if (pending) begin
                            for (int b = 0; b < 3; b++)
                                for (int i = 0; i < 5; i++)
                                    active[b][i] <= shadow[b][i];
                            pending <= 1'b0;
                        end
                    end
                end
                MAC: begin
                    // Feedback taps (a1, a2) are subtracted
                    if (tap >= 3'd3)
                        acc <= acc - prod_ext;
                    else
                        acc <= acc + prod_ext;
                    if (tap == 3'd4)
                        state <= WB;
                    else
                        tap <= tap + 3'd1;
                end
                WB: begin
                    case (band)
                        2'd0:    low_r  <= result;
                        2'd1:    mid_r  <= result;
                        default: high_r <= result;
                    endcase
                    y2[band] <= y1[band];
                    y1[band] <= result;
                    acc      <= '0;
                    if (band == 2'd2) begin
                        x2      <= x1;
                        x1      <= x_cur;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        band  <= band + 2'd1;
                        tap   <= 3'd0;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
            // A commit on the accept edge stays pending for the following sample
            if (bus.coef_commit)
                pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_eq_biquad_scheduler.sv
module tb_eq_biquad_scheduler;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    eq_biquad_scheduler_if bus_if ();

    eq_biquad_scheduler #(.ACC_W(36), .FRAC(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int sh [3][5];
    int ac [3][5];
    bit pend;
    int mx1, mx2;
    int my1 [3];
    int my2 [3];
    int p [3];
    int remain;
    int e_low = 0, e_mid = 0, e_high = 0;
    bit e_valid = 0, e_busy = 0, e_over = 0;
    bit take;
    int xin;

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int biquad(input int b, input int x);
        longint a;
        a = longint'(ac[b][0]) * longint'(x)
          + longint'(ac[b][1]) * longint'(mx1)
          + longint'(ac[b][2]) * longint'(mx2)
          - longint'(ac[b][3]) * longint'(my1[b])
          - longint'(ac[b][4]) * longint'(my2[b]);
        return sat16(a >>> 14);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 5; i++) begin
                sh[b][i] = (i == 0) ? 16384 : 0;
                ac[b][i] = (i == 0) ? 16384 : 0;
            end
            my1[b] = 0; my2[b] = 0; p[b] = 0;
        end
        mx1 = 0; mx2 = 0; pend = 0; remain = 0;
        e_low = 0; e_mid = 0; e_high = 0;
        e_valid = 0; e_busy = 0; e_over = 0;
    endtask

    // Model advances one clock: outputs appear 6/12/18 edges after acceptance
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            e_valid = 0;
            take = bus_if.sample_valid && (remain == 0);
            if (bus_if.sample_valid && remain != 0) e_over = 1;
            if (remain > 0) begin
                remain--;
                case (18 - remain)
                    6:  e_low = p[0];
                    12: e_mid = p[1];
                    18: begin e_high = p[2]; e_valid = 1; e_busy = 0; end
                    default: ;
                endcase
            end
            if (take) begin
                if (pend) begin
                    for (int b = 0; b < 3; b++)
                        for (int i = 0; i < 5; i++)
                            ac[b][i] = sh[b][i];
                    pend = 0;
                end
                xin = int'($signed(bus_if.sample_in));
                for (int b = 0; b < 3; b++) p[b] = biquad(b, xin);
                for (int b = 0; b < 3; b++) begin
                    my2[b] = my1[b];
                    my1[b] = p[b];
                end
                mx2 = mx1;
                mx1 = xin;
                remain = 18;
                e_busy = 1;
            end
            if (bus_if.coef_commit) pend = 1;
            if (bus_if.coef_we && bus_if.coef_band < 2'd3 && bus_if.coef_idx < 3'd5)
                sh[bus_if.coef_band][bus_if.coef_idx] = int'($signed(bus_if.coef_data));
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(posedge clk) begin
        #1;
        chk("cyc_low",   int'($signed(bus_if.low_out)),  e_low);
        chk("cyc_mid",   int'($signed(bus_if.mid_out)),  e_mid);
        chk("cyc_high",  int'($signed(bus_if.high_out)), e_high);
        chk("cyc_valid", int'(bus_if.out_valid), int'(e_valid));
        chk("cyc_busy",  int'(bus_if.busy),      int'(e_busy));
        chk("cyc_over",  int'(bus_if.overrun),   int'(e_over));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus_if.sample_in    = '0;
        bus_if.sample_valid = 1'b0;
        bus_if.coef_we      = 1'b0;
        bus_if.coef_band    = '0;
        bus_if.coef_idx     = '0;
        bus_if.coef_data    = '0;
        bus_if.coef_commit  = 1'b0;
    endtask

    task automatic send(input int x);
        @(negedge clk);
        bus_if.sample_in    = 16'(x);
        bus_if.sample_valid = 1'b1;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
    endtask

    task automatic wr_coef(input int b, input int i, input int d);
        @(negedge clk);
        bus_if.coef_we   = 1'b1;
        bus_if.coef_band = 2'(b);
        bus_if.coef_idx  = 3'(i);
        bus_if.coef_data = 16'(d);
        @(negedge clk);
        bus_if.coef_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        bus_if.coef_commit = 1'b1;
        @(negedge clk);
        bus_if.coef_commit = 1'b0;
    endtask

    task automatic wait_out(output int n);
        bit seen;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_if.out_valid) seen = 1;
        end
        chk("out_valid_seen", int'(seen), 1);
    endtask

    task automatic expect_out(input string tag, input int l, input int m, input int h);
        chk({tag, "_low"},  int'($signed(bus_if.low_out)),  l);
        chk({tag, "_mid"},  int'($signed(bus_if.mid_out)),  m);
        chk({tag, "_high"}, int'($signed(bus_if.high_out)), h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int n;
    int got_valid;

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_out("reset", 0, 0, 0);
        chk("reset_busy", int'(bus_if.busy), 0);
        chk("reset_over", int'(bus_if.overrun), 0);

        // Passthrough after reset
        send(1000);
        wait_out(n);
        chk("pass_latency", n, 18);
        expect_out("pass", 1000, 1000, 1000);

        // Overrun: second strobe 5 cycles after accept is dropped
        send(2000);
        repeat (4) @(negedge clk);
        bus_if.sample_in = 16'sd7777;
        bus_if.sample_valid = 1'b1;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        wait_out(n);
        expect_out("ovr", 2000, 2000, 2000);
        chk("ovr_flag", int'(bus_if.overrun), 1);
        send(1000);
        wait_out(n);
        expect_out("ovr_next", 1000, 1000, 1000);
        chk("ovr_sticky", int'(bus_if.overrun), 1);

        // Gain with commit on mid band
        wr_coef(1, 0, 8192);
        commit();
        send(1000);
        wait_out(n);
        expect_out("gain", 1000, 500, 1000);

        // Write on the accept edge must not reach this sample's coefficients
        wr_coef(1, 0, 16384);
        commit();
        @(negedge clk);
        bus_if.sample_in = 16'sd1000;
        bus_if.sample_valid = 1'b1;
        bus_if.coef_we = 1'b1;
        bus_if.coef_band = 2'd1;
        bus_if.coef_idx = 3'd0;
        bus_if.coef_data = 16'sd4096;
        @(negedge clk);
        bus_if.sample_valid = 1'b0;
        bus_if.coef_we = 1'b0;
        wait_out(n);
        expect_out("acc_edge", 1000, 1000, 1000);
        commit();
        send(1000);
        wait_out(n);
        expect_out("late_wr", 1000, 250, 1000);
        wr_coef(1, 0, 16384);
        // Ignored writes: band 3 and idx 6
        wr_coef(3, 0, 100);
        wr_coef(0, 6, 100);

        // Saturation on low band
        wr_coef(0, 0, 32767);
        commit();
        send(30000);
        wait_out(n);
        expect_out("sat_pos", 32767, 30000, 30000);
        send(-30000);
        wait_out(n);
        expect_out("sat_neg", -32768, -30000, -30000);

        // Reset mid-operation
        send(1234);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        got_valid = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) got_valid = 1;
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) got_valid = 1;
        end
        chk("rst_no_valid", got_valid, 0);
        expect_out("rst", 0, 0, 0);
        chk("rst_over", int'(bus_if.overrun), 0);
        send(1000);
        wait_out(n);
        expect_out("rst_next", 1000, 1000, 1000);

        // Recursion on high band from clean history
        do_reset();
        wr_coef(2, 3, -8192);
        commit();
        send(16384);
        wait_out(n);
        expect_out("rec0", 16384, 16384, 16384);
        send(0);
        wait_out(n);
        expect_out("rec1", 0, 0, 8192);
        send(0);
        wait_out(n);
        expect_out("rec2", 0, 0, 4096);
        send(0);
        wait_out(n);
        expect_out("rec3", 0, 0, 2048);

        // Randomized traffic checked cycle-by-cycle by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus_if.sample_valid = ($urandom % 8) == 0;
            bus_if.sample_in    = 16'($urandom);
            bus_if.coef_we      = ($urandom % 4) == 0;
            bus_if.coef_band    = 2'($urandom);
            bus_if.coef_idx     = 3'($urandom);
            bus_if.coef_data    = 16'(int'($urandom_range(0, 32767)) - 16384);
            bus_if.coef_commit  = ($urandom % 16) == 0;
            if (c == 1500) reset = 1'b1;
            if (c == 1503) reset = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eq_biquad_scheduler.md
# eq_biquad_scheduler

Time-multiplexed controller for the three-band equalizer. It runs all three biquad sections (low, mid, high) on one shared 16x16 multiplier-accumulator instead of three parallel filter instances. For each accepted input sample it sequences 15 MAC operations, keeps per-band feedback history, and applies coefficient updates atomically at sample boundaries through a double-buffered coefficient bank. It sits between the audio sample source and the band mixer.

## Interface
- `ACC_W`, default 36: accumulator width, in bits.
- `FRAC`, default 14: number of fractional bits in the coefficients (signed Q2.14).
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `sample_in` in 16: signed input sample x[n].
- `sample_valid` in 1: one-cycle strobe meaning sample_in is valid.
- `coef_we` in 1: write enable for the shadow coefficient bank.
- `coef_band` in 2: band select for a coefficient write (0 = low, 1 = mid, 2 = high; 3 is ignored).
- `coef_idx` in 3: coefficient select (0 = b0, 1 = b1, 2 = b2, 3 = a1, 4 = a2; 5 to 7 are ignored).
- `coef_data` in 16: signed Q2.14 coefficient value.
- `coef_commit` in 1: strobe requesting a shadow-to-active copy.
- `low_out`, `mid_out`, `high_out` out 16 each: signed filtered outputs y[n] per band.
- `out_valid` out 1: one-cycle strobe; all three band outputs are updated and valid.
- `busy` out 1: high while a sample is being processed.
- `overrun` out 1: sticky flag; a sample was dropped because it arrived while busy.

## Operation
- **Filter equation**, per band: y = b0·x[n] + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - x1 and x2 are shared by all three bands.
  - y1 and y2 are held separately for each band.
- **Arithmetic**
  - Each product is a 32-bit signed value, sign-extended to ACC_W.
  - For a1 and a2 the product is subtracted.
  - The result is acc >>> FRAC (arithmetic shift), then saturated to [−32768, 32767].
  - The saturated value is both the band output and the value pushed into that band's y1.
- **FSM states**: IDLE, MAC, WB.
  - IDLE: when sample_valid=1, latch sample_in, clear acc, set band=0 and tap=0, go to MAC.
  - MAC: one product per cycle, in tap order b0, b1, b2, a1, a2. After tap 4, go to WB.
  - WB: write the saturated result to the band output register, update that band's y2←y1 and y1←result, then clear acc.
    - If band<2: increment band, set tap=0, return to MAC.
    - If band=2: shift x2←x1 and x1←x, pulse out_valid, return to IDLE.
- **Dropped samples**: sample_valid while the FSM is not in IDLE is dropped. overrun is set and stays set until reset. State and outputs are unaffected.
- **Coefficient bank**
  - Shadow and active banks, each 3×5×16 bits. coef_we writes the shadow bank at any time. Writes with band=3 or idx>4 are ignored.
  - coef_commit sets a pending flag. The active bank is loaded from the shadow bank on the edge where the next sample is accepted from IDLE, and the pending flag clears on that edge. A sample therefore never uses a mix of old and new coefficients.
  - If coef_we occurs on the copy edge, the old shadow contents are copied; the write lands in the shadow bank only.
  - A coef_commit while a commit is already pending has no extra effect.
- **Reset state**, applied asynchronously:
  - FSM in IDLE; all x and y history cleared to 0; acc = 0.
  - low_out, mid_out, high_out = 0; out_valid = 0; busy = 0; overrun = 0; commit pending = 0.
  - Both coefficient banks: b0 = 16384 (1.0), all other coefficients 0, so every band is passthrough.

## Timing
- Let E0 be the edge that accepts a sample.
- Band 0: MAC on E1 to E5, WB on E6. Band 1: MAC on E7 to E11, WB on E12. Band 2: MAC on E13 to E17, WB on E18.
- Each band output changes only on its own WB edge.
- out_valid is high for exactly one cycle, after E18. Latency is 18 cycles.
- busy rises after E0 and falls after E18.
- The earliest next acceptance is at E19, so the maximum input rate is one sample per 19 cycles. A sample_valid in the same cycle that out_valid is high is accepted.
- Reset asserted mid-sequence aborts immediately. No out_valid is produced, and history returns to zero.

## Test plan
- **Passthrough after reset**: sample_in=1000 → out_valid exactly 18 cycles later; low, mid and high all read 1000; busy high for 18 cycles.
- **Gain and atomic commit**
  - Write b0=8192 for the mid band, then commit, then send x=1000 → mid_out=500; low and high stay at 1000.
  - coef_we on the accept edge → not applied to that sample.
- **Saturation**: b0=32767 on the low band, x=30000 → low_out=32767. With x=−30000 → low_out=−32768.
- **Recursion**: a1=−8192 on the high band. Impulse x=16384, then zeros → high_out = 16384, 8192, 4096, 2048 on successive samples.
- **Overrun**: sample_valid pulsed 5 cycles after an accepted sample → that sample is dropped; overrun=1 and stays 1; outputs match the single-sample result. The next sample after out_valid is processed normally.
- **Reset mid-operation**: assert reset 10 cycles into processing → out_valid never pulses; all outputs are 0. The next sample x=1000 gives 1000 on all bands, with no history carried over.
